// File: rtl/scope_pkg.sv
// Shared types and constants for the oscilloscope capture controller.
// The FSM state enum is exported so checkers can bind to r_state directly.
package scope_pkg;

    localparam int DATA_W_DEF = 12;
    localparam int ADDR_W_DEF = 8;

    localparam logic SLOPE_RISE = 1'b1;
    localparam logic SLOPE_FALL = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PREFILL   = 3'd1,
        ST_WAIT_TRIG = 3'd2,
        ST_POST      = 3'd3,
        ST_DONE      = 3'd4
    } state_e;

    // Capture is in progress in every state that writes the buffer.
    function automatic logic is_busy(input state_e s);
        return (s == ST_PREFILL) || (s == ST_WAIT_TRIG) || (s == ST_POST);
    endfunction

endpackage

// File: rtl/scope_trig_detect.sv
// Edge comparator: flags a level crossing between the previous and current sample.
// Purely combinational; unsigned full-width comparisons.
module scope_trig_detect
    import scope_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] sample,
    input  logic [DATA_W-1:0] prev_sample,
    input  logic              prev_valid,
    input  logic [DATA_W-1:0] trig_level,
    input  logic              trig_slope,
    output logic              hit
);

    logic w_rise;
    logic w_fall;

    assign w_rise = (prev_sample < trig_level) && (sample >= trig_level);
    assign w_fall = (prev_sample > trig_level) && (sample <= trig_level);

    // Without a previous sample there is no edge to detect.
    assign hit = prev_valid && ((trig_slope == SLOPE_RISE) ? w_rise : w_fall);

endmodule

// File: rtl/scope_capture_ctrl.sv
// Pre/post-trigger capture controller writing a circular sample buffer.
// Holds PRE samples before the trigger and DEPTH-PRE from the trigger onwards.
module scope_capture_ctrl
    import scope_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int PRE    = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample,
    input  logic [DATA_W-1:0] trig_level,
    input  logic              trig_slope,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] trig_addr
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] PRE_LAST  = ADDR_W'(PRE - 1);
    localparam logic [ADDR_W-1:0] POST_LAST = ADDR_W'(DEPTH - PRE - 1);

    state_e            r_state;
    state_e            w_next;
    logic              w_active;
    logic              w_accept;
    logic              w_arm;
    logic              w_hit;

    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] r_pre_cnt;
    logic [ADDR_W-1:0] r_post_cnt;
    logic [DATA_W-1:0] r_prev_sample;
    logic              r_prev_valid;

    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;
    logic [ADDR_W-1:0] r_trig_addr;

    scope_trig_detect #(
        .DATA_W (DATA_W)
    ) u_trig_detect (
        .sample      (sample),
        .prev_sample (r_prev_sample),
        .prev_valid  (r_prev_valid),
        .trig_level  (trig_level),
        .trig_slope  (trig_slope),
        .hit         (w_hit)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Sample handshake: valid-only, no backpressure. A sample is accepted on
    // every cycle sample_valid=1 while capturing and abort=0; it is written
    // exactly one cycle later.
    always_comb begin
        w_next   = r_state;
        w_active = 1'b0;
        w_arm    = 1'b0;
        w_accept = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next = ST_PREFILL;
                    w_arm  = 1'b1;
                end
            end
            ST_PREFILL: begin
                w_active = 1'b1;
                if (sample_valid && (r_pre_cnt == PRE_LAST)) begin
                    w_next = ST_WAIT_TRIG;
                end
            end
            ST_WAIT_TRIG: begin
                w_active = 1'b1;
                if (sample_valid && w_hit) begin
                    w_next = ST_POST;
                end
            end
            ST_POST: begin
                w_active = 1'b1;
                if (sample_valid && (r_post_cnt == POST_LAST)) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (start) begin
                    w_next = ST_PREFILL;
                    w_arm  = 1'b1;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
        // Abort overrides everything, including a simultaneous start.
        if (abort) begin
            w_next = ST_IDLE;
            w_arm  = 1'b0;
        end
        w_accept = w_active && sample_valid && !abort;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr         <= '0;
            r_pre_cnt     <= '0;
            r_post_cnt    <= '0;
            r_prev_sample <= '0;
            r_prev_valid  <= 1'b0;
            r_wr_en       <= 1'b0;
            r_wr_addr     <= '0;
            r_wr_data     <= '0;
            r_trig_addr   <= '0;
        end else begin
            r_wr_en <= w_accept;
            if (w_arm) begin
                r_ptr        <= '0;
                r_pre_cnt    <= '0;
                r_post_cnt   <= '0;
                r_prev_valid <= 1'b0;
            end else if (w_accept) begin
                r_ptr         <= r_ptr + ADDR_W'(1);
                r_wr_addr     <= r_ptr;
                r_wr_data     <= sample;
                r_prev_sample <= sample;
                r_prev_valid  <= 1'b1;
                case (r_state)
                    ST_PREFILL: begin
                        r_pre_cnt <= r_pre_cnt + ADDR_W'(1);
                    end
                    ST_WAIT_TRIG: begin
                        // The trigger sample itself is post sample number one.
                        if (w_hit) begin
                            r_post_cnt  <= ADDR_W'(1);
                            r_trig_addr <= r_ptr;
                        end
                    end
                    ST_POST: begin
                        r_post_cnt <= r_post_cnt + ADDR_W'(1);
                    end
                    default: begin
                        r_post_cnt <= r_post_cnt;
                    end
                endcase
            end
        end
    end

    assign wr_en     = r_wr_en;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign trig_addr = r_trig_addr;
    assign busy      = is_busy(r_state);
    assign done      = (r_state == ST_DONE);

endmodule

// File: doc/scope_capture_ctrl.md
SCOPE_CAPTURE_CTRL -- requirements
Module: scope_capture_ctrl

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- DATA_W, 12: sample width.
- ADDR_W, 8: capture buffer address width; buffer depth is DEPTH = 2^ADDR_W.
- PRE, 64: number of pre-trigger samples; legal range 1..DEPTH-2.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1: single clock.
- reset_n, in, 1: asynchronous, active-low reset.
- start, in, 1: one-cycle pulse that arms a capture.
- abort, in, 1: cancels a capture.
- sample_valid, in, 1: strobe qualifying sample, driven by the synchronized sample path.
- sample, in, DATA_W: unsigned sample.
- trig_level, in, DATA_W: unsigned trigger threshold.
- trig_slope, in, 1: 1 = rising, 0 = falling.
- wr_en, out, 1: buffer write strobe.
- wr_addr, out, ADDR_W: buffer write address.
- wr_data, out, DATA_W: buffer write data.
- busy, out, 1: capture in progress.
- done, out, 1: capture complete.
- trig_addr, out, ADDR_W: buffer address of the trigger sample.

Function
REQ-003 The FSM SHALL have the states IDLE, PREFILL, WAIT_TRIG, POST and DONE.
REQ-004 IDLE -> PREFILL on start. On that transition the write pointer, the pre counter, the post counter and the prev_valid flag SHALL clear.
REQ-005 In PREFILL, WAIT_TRIG and POST, every sample_valid SHALL produce wr_en=1 on the next cycle, with wr_data = sample and wr_addr = the current pointer; the pointer then increments modulo DEPTH. Write latency is exactly 1 cycle.
REQ-006 In IDLE and DONE, wr_en SHALL be 0 and sample_valid SHALL be ignored.
REQ-007 PREFILL -> WAIT_TRIG on the cycle the PRE-th sample is accepted. The trigger condition SHALL be ignored during PREFILL.
REQ-008 Every accepted sample SHALL be registered as prev_sample and set prev_valid. No trigger can fire while prev_valid=0.
REQ-009 The trigger condition SHALL be:
- rising: prev_sample < trig_level AND sample >= trig_level;
- falling: prev_sample > trig_level AND sample <= trig_level.
Comparisons are unsigned, full DATA_W.
REQ-010 In WAIT_TRIG, a valid sample meeting the trigger condition SHALL be written, SHALL latch trig_addr = its wr_addr, and SHALL move the FSM to POST. That trigger sample counts as post sample 1.
REQ-011 In WAIT_TRIG, the pointer SHALL wrap freely with no limit on the wait time.
REQ-012 POST -> DONE on acceptance of post sample DEPTH-PRE, so the buffer holds exactly DEPTH samples, the oldest at trig_addr - PRE (mod DEPTH).
REQ-013 Status outputs:
- busy = 1 exactly in PREFILL, WAIT_TRIG and POST.
- done = 1 exactly in DONE.
- trig_addr holds its value until the next start.
REQ-014 In DONE, start SHALL re-arm the capture (DONE -> PREFILL, same clears as REQ-004).
REQ-015 start while busy SHALL be ignored.
REQ-016 abort in any state SHALL go to IDLE on the next edge:
- a write already pending from the previous cycle still completes;
- no further writes are issued;
- done stays 0.
REQ-017 When start and abort are asserted in the same cycle, abort SHALL win.
REQ-018 trig_level and trig_slope SHALL be sampled every cycle; changes mid-capture take effect immediately.

Reset
REQ-019 While reset_n=0, the block SHALL asynchronously force:
- the FSM to IDLE;
- wr_en, busy, done = 0;
- wr_addr, wr_data, trig_addr, the pointer, both counters and prev_sample = 0;
- prev_valid = 0.
REQ-020 Reset release SHALL be synchronous to clk. The first start is honoured on the first rising edge after release.

Structure
REQ-021 A shared package scope_pkg SHALL hold:
- the FSM state enum;
- DATA_W and ADDR_W defaults;
- the slope encoding constants.
REQ-022 The edge comparator SHALL be a sub-module, scope_trig_detect, with inputs sample, prev_sample, prev_valid, trig_level and trig_slope, and one combinational output hit.

Verification (DEPTH=256, PRE=64)
REQ-023 Reset: assert reset_n=0 mid-POST -> all outputs 0 immediately; after release the FSM is IDLE and busy=0.
REQ-024 Rising trigger: start, then valid ramp 0x000,0x010,...; trig_level=0x800, slope=1 -> trigger on sample 0x800 (index 128), trig_addr=0x80, done rises one cycle after the 320th accepted sample, total wr_en pulses = 320.
REQ-025 Prefill masking: crossing 0x7F0->0x810 at sample index 10 -> no trigger; a later crossing at index 100 -> trig_addr=0x64.
REQ-026 Falling trigger and wrap: 300 samples of 0xFFF, then 0x000 with slope=0, level=0x800 -> trig_addr=(300 mod 256)=0x2C, done after 191 further samples.
REQ-027 Abort: abort asserted at post sample 50 -> IDLE next cycle, done=0; start and abort asserted together in IDLE -> FSM stays IDLE.
REQ-028 Re-arm: start in DONE -> busy=1 next cycle, pointer restarts at 0x00; start pulsed during WAIT_TRIG is ignored (trig_addr unchanged).
